bldc_commutation_ctrl: RTL and testbench
========================================

BLDC_COMMUTATION_CTRL -- requirements
Module: bldc_commutation_ctrl

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: number of consecutive cycles a synchronized hall code must stay stable before it is accepted (range 1..15).
REQ-002 SHALL have parameter STEP_W, default 16: width of step_count.
REQ-003 pclk  in  1  sole clock; all logic rising-edge.
REQ-004 preset_n  in  1  asynchronous, active-low reset.
REQ-005 hall_values  in  3  raw hall sensor inputs {C,B,A}, asynchronous to pclk.
REQ-006 enable  in  1  1 = drive motor; 0 = outputs off and fault cleared.
REQ-007 dir_cmd  in  1  commanded direction: 0 = forward, 1 = reverse.
REQ-008 brake  in  1  1 = all low-side switches on.
REQ-009 dead_time  in  8  gap in pclk cycles with all switches off before any new pattern is applied.
REQ-010 phase_enable  out  6  bit 2k = high side of phase k, bit 2k+1 = low side of phase k; A=0, B=1, C=2; registered.
REQ-011 detected_dir  out  2  01 = forward, 10 = reverse, 00 = unknown; registered.
REQ-012 hall_fault  out  1  sticky fault: invalid hall code accepted.
REQ-013 step_count  out  STEP_W  signed step position; wraps modulo 2^STEP_W.

Function
REQ-014 SHALL pass hall_values through a 2-flop synchronizer, then accept a code once it has been stable for FILTER_LEN cycles; accepted latency is 2+FILTER_LEN cycles.
REQ-015 SHALL map accepted codes to sectors: 001->0, 011->1, 010->2, 110->3, 100->4, 101->5; 000 and 111 are invalid.
REQ-016 SHALL drive the forward (high, low) pair per sector: 0:(A,B), 1:(A,C), 2:(B,C), 3:(B,A), 4:(C,A), 5:(C,B); for reverse, high and low are swapped.
REQ-017 SHALL set the brake pattern to 6'b101010.
REQ-018 SHALL implement the FSM states IDLE, GAP, DRIVE, FAULT.
REQ-019 In IDLE, phase_enable SHALL be 0; on enable=1 with a valid sector, the FSM SHALL go to GAP.
REQ-020 In DRIVE, any change of target pattern (new sector, dir_cmd, or brake edge) SHALL go to GAP.
REQ-021 GAP SHALL load dead_time when entered; phase_enable SHALL be 0 for D cycles and the target pattern SHALL appear on cycle t+D+1, where t is the change cycle; D=0 gives the new pattern at t+1.
REQ-022 A target change during GAP SHALL update the target and restart the gap counter with the current dead_time.
REQ-023 Priority SHALL be: invalid accepted code (-> FAULT, hall_fault=1) > enable=0 (-> IDLE) > brake > normal commutation.
REQ-024 In FAULT, phase_enable SHALL be 0 and hall_fault SHALL hold 1 until enable=0, which clears it and returns to IDLE.
REQ-025 On each valid-to-valid sector acceptance:
- new = old+1 mod 6: detected_dir=01, step_count+1.
- new = old-1 mod 6: detected_dir=10, step_count-1.
- any other jump: detected_dir=00, step_count unchanged.
REQ-026 Step tracking SHALL run regardless of FSM state (including IDLE and brake) while no fault is held.
REQ-027 phase_enable SHALL never assert both sides of one phase, except in the brake pattern, which asserts low sides only.

Reset
REQ-028 On preset_n=0, the block SHALL immediately set phase_enable=0, detected_dir=00, hall_fault=0, step_count=0, state=IDLE, synchronizer/filter registers to 000, and "no previous sector".
REQ-029 The first valid sector accepted after reset SHALL NOT update detected_dir or step_count.
REQ-030 Reset asserted mid-GAP or mid-DRIVE SHALL take effect without waiting for a pclk edge.

Verification
REQ-031 Scenario: hall=001 held, enable=1, dead_time=3 -> phase_enable=0 for 3 cycles after acceptance, then 6'b001001.
REQ-032 Scenario: forward sequence 001,011,010,110,100,101,001 -> detected_dir=01, step_count=6, each change preceded by a 3-cycle zero gap.
REQ-033 Scenario: reverse order of the six codes -> detected_dir=10, step_count=-6 (0xFFFA); a 1-cycle hall glitch with FILTER_LEN=4 -> no change.
REQ-034 Scenario: hall=111 while driving -> hall_fault=1 and phase_enable=0; release to 001 keeps the fault; enable=0 clears it.
REQ-035 Scenario: brake=1 in DRIVE with dead_time=0 -> 6'b101010 on the next cycle; a dir_cmd toggle during GAP restarts the gap count.
REQ-036 Scenario: preset_n pulsed low mid-GAP -> all outputs 0 asynchronously; after release, the first accepted code leaves step_count=0.

Source files
------------

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation controller: filters the hall sensors, tracks rotor steps and
// drives the six bridge switches through a dead-time gap on every pattern change.
module bldc_commutation_ctrl #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned STEP_W     = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [2:0]        hall_values,
    input  logic              enable,
    input  logic              dir_cmd,
    input  logic              brake,
    input  logic [7:0]        dead_time,
    output logic [5:0]        phase_enable,
    output logic [1:0]        detected_dir,
    output logic              hall_fault,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [3:0] FiltLen      = 4'(FILTER_LEN);
    localparam logic [5:0] BrakePattern = 6'b101010;

    typedef enum logic [1:0] {StIdle, StGap, StDrive, StFault} state_t;

    function automatic logic code_valid(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    function automatic logic [2:0] code_sector(input logic [2:0] code);
        logic [2:0] sec;
        sec = 3'd0;
        case (code)
            3'b001:  sec = 3'd0;
            3'b011:  sec = 3'd1;
            3'b010:  sec = 3'd2;
            3'b110:  sec = 3'd3;
            3'b100:  sec = 3'd4;
            3'b101:  sec = 3'd5;
            default: sec = 3'd0;
        endcase
        return sec;
    endfunction

    // Bit 2k = high side, bit 2k+1 = low side of phase k; reverse swaps the two sides.
    function automatic logic [5:0] sector_pattern(input logic [2:0] sec, input logic rev);
        logic [5:0] pat;
        pat = 6'b000000;
        case ({rev, sec})
            4'b0_000: pat = 6'b001001;
            4'b0_001: pat = 6'b100001;
            4'b0_010: pat = 6'b100100;
            4'b0_011: pat = 6'b000110;
            4'b0_100: pat = 6'b010010;
            4'b0_101: pat = 6'b011000;
            4'b1_000: pat = 6'b000110;
            4'b1_001: pat = 6'b010010;
            4'b1_010: pat = 6'b011000;
            4'b1_011: pat = 6'b001001;
            4'b1_100: pat = 6'b100001;
            4'b1_101: pat = 6'b100100;
            default:  pat = 6'b000000;
        endcase
        return pat;
    endfunction

    logic [2:0]        sync1_q, sync2_q, cand_q, acc_q;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept, new_valid;
    state_t            state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic [5:0]        target_q, target_d, target_now;
    logic [5:0]        phase_q, phase_d;
    logic              load_gap;
    logic [1:0]        dir_q, dir_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [2:0]        old_sec, new_sec, old_next, old_prev;

    // Stability counter includes the current sample, so acceptance lands 2+FILTER_LEN cycles
    // after the input settles. It resets saturated so the all-zero reset code is never accepted.
    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q != cand_q) begin
            cnt_d = 4'd1;
        end else if (cnt_q != FiltLen) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign accept    = (cnt_d == FiltLen) && (sync2_q != acc_q);
    assign new_valid = code_valid(sync2_q);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cand_q  <= 3'b000;
            cnt_q   <= FiltLen;
            acc_q   <= 3'b000;
        end else begin
            sync1_q <= hall_values;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (accept) begin
                acc_q <= sync2_q;
            end
        end
    end

    assign target_now = brake ? BrakePattern : sector_pattern(code_sector(acc_q), dir_cmd);

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        target_d = target_q;
        phase_d  = phase_q;
        load_gap = 1'b0;
        if (accept && !new_valid) begin
            state_d = StFault;
            phase_d = 6'b000000;
        end else if (state_q == StFault) begin
            phase_d = 6'b000000;
            if (!enable) begin
                state_d = StIdle;
            end
        end else if (!enable) begin
            state_d = StIdle;
            phase_d = 6'b000000;
        end else begin
            case (state_q)
                StIdle: begin
                    phase_d = 6'b000000;
                    if (code_valid(acc_q)) begin
                        load_gap = 1'b1;
                    end
                end
                StGap: begin
                    if (target_now != target_q) begin
                        load_gap = 1'b1;
                    end else if (gap_q == 8'd0) begin
                        state_d = StDrive;
                        phase_d = target_q;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                StDrive: begin
                    if (target_now != target_q) begin
                        load_gap = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
            // A zero dead time skips the gap so the new pattern lands on the next edge.
            if (load_gap) begin
                target_d = target_now;
                if (dead_time == 8'd0) begin
                    state_d = StDrive;
                    phase_d = target_now;
                end else begin
                    state_d = StGap;
                    gap_d   = dead_time - 8'd1;
                    phase_d = 6'b000000;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q  <= StIdle;
            gap_q    <= 8'd0;
            target_q <= 6'b000000;
            phase_q  <= 6'b000000;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            target_q <= target_d;
            phase_q  <= phase_d;
        end
    end

    assign old_sec  = code_sector(acc_q);
    assign new_sec  = code_sector(sync2_q);
    assign old_next = (old_sec == 3'd5) ? 3'd0 : old_sec + 3'd1;
    assign old_prev = (old_sec == 3'd0) ? 3'd5 : old_sec - 3'd1;

    // Only valid-to-valid transitions move the step counter; an invalid previous code
    // (reset or post-fault) acts as "no previous sector".
    always_comb begin
        dir_d  = dir_q;
        step_d = step_q;
        if (accept && new_valid && code_valid(acc_q) && (state_q != StFault)) begin
            if (new_sec == old_next) begin
                dir_d  = 2'b01;
                step_d = step_q + STEP_W'(1);
            end else if (new_sec == old_prev) begin
                dir_d  = 2'b10;
                step_d = step_q - STEP_W'(1);
            end else begin
                dir_d  = 2'b00;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            dir_q  <= 2'b00;
            step_q <= '0;
        end else begin
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign phase_enable = phase_q;
    assign detected_dir = dir_q;
    assign hall_fault   = (state_q == StFault);
    assign step_count   = step_q;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Self-checking bench: directed scenarios plus randomized hall/command traffic compared every
// cycle against a time-stamped behavioural model of the commutation rules.
module tb_bldc_commutation_ctrl;

    localparam int FL = 4;
    localparam int SW = 16;
    localparam logic [2:0] CODES [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    localparam int HI [6] = '{0, 0, 1, 1, 2, 2};
    localparam int LO [6] = '{1, 2, 2, 0, 0, 1};

    logic          pclk = 1'b0;
    logic          preset_n = 1'b1;
    logic [2:0]    hall_values;
    logic          enable, dir_cmd, brake;
    logic [7:0]    dead_time;
    logic [5:0]    phase_enable;
    logic [1:0]    detected_dir;
    logic          hall_fault;
    logic [SW-1:0] step_count;

    bldc_commutation_ctrl #(.FILTER_LEN(FL), .STEP_W(SW)) dut (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .hall_values  (hall_values),
        .enable       (enable),
        .dir_cmd      (dir_cmd),
        .brake        (brake),
        .dead_time    (dead_time),
        .phase_enable (phase_enable),
        .detected_dir (detected_dir),
        .hall_fault   (hall_fault),
        .step_count   (step_count)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    bit jitter = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: accepted code, fault flag, driving flag, latched target and the cycle
    // number at which that target becomes visible.
    logic [2:0]    hist [$];
    logic [2:0]    m_acc;
    bit            m_fault, m_active;
    logic [5:0]    m_tgt, m_phase;
    int            m_ready, m_n;
    logic [1:0]    m_dir;
    logic [SW-1:0] m_step;

    function automatic bit valid_code(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    function automatic int sector_of(input logic [2:0] c);
        int s;
        s = -1;
        for (int i = 0; i < 6; i++) if (CODES[i] == c) s = i;
        return s;
    endfunction

    function automatic logic [5:0] pattern_of(input logic [2:0] c, input bit rev, input bit brk);
        logic [5:0] p;
        int s, h, l;
        p = 6'b000000;
        if (brk) return 6'b101010;
        if (!valid_code(c)) return p;
        s = sector_of(c);
        h = rev ? LO[s] : HI[s];
        l = rev ? HI[s] : LO[s];
        p[2*h]   = 1'b1;
        p[2*l+1] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < FL + 2; i++) hist.push_back(3'b000);
        m_acc = 3'b000; m_fault = 0; m_active = 0; m_tgt = '0; m_phase = '0;
        m_ready = 0; m_n = 0; m_dir = 2'b00; m_step = '0;
    endtask

    task automatic model_step();
        logic [5:0] tgt_now;
        logic [2:0] v;
        bit stable, acc_ev, fault_before;
        int d;
        m_n++;
        tgt_now = pattern_of(m_acc, dir_cmd, brake);
        hist.push_front(hall_values);
        void'(hist.pop_back());
        // Accept when the FL samples that have cleared the synchronizer all agree.
        v = hist[2];
        stable = 1'b1;
        for (int i = 3; i <= FL + 1; i++) if (hist[i] != v) stable = 1'b0;
        acc_ev = stable && (v != m_acc);
        fault_before = m_fault;
        if (acc_ev && !valid_code(v)) begin
            m_fault = 1; m_active = 0;
        end else if (m_fault) begin
            if (!enable) m_fault = 0;
        end else if (!enable) begin
            m_active = 0;
        end else if (!m_active) begin
            if (valid_code(m_acc)) begin
                m_active = 1; m_tgt = tgt_now; m_ready = m_n + int'(dead_time);
            end
        end else if (tgt_now != m_tgt) begin
            m_tgt = tgt_now; m_ready = m_n + int'(dead_time);
        end
        m_phase = (m_active && m_n >= m_ready) ? m_tgt : 6'b000000;
        if (acc_ev && valid_code(v) && valid_code(m_acc) && !fault_before) begin
            d = (sector_of(v) - sector_of(m_acc) + 6) % 6;
            if (d == 1) begin
                m_dir = 2'b01; m_step = m_step + 1'b1;
            end else if (d == 5) begin
                m_dir = 2'b10; m_step = m_step - 1'b1;
            end else begin
                m_dir = 2'b00;
            end
        end
        if (acc_ev) m_acc = v;
    endtask

    task automatic cycle();
        logic shoot;
        model_step();
        @(posedge pclk);
        @(negedge pclk);
        shoot = (phase_enable[0] & phase_enable[1]) | (phase_enable[2] & phase_enable[3]) |
                (phase_enable[4] & phase_enable[5]);
        check("phase", 32'(phase_enable), 32'(m_phase));
        check("dir", 32'(detected_dir), 32'(m_dir));
        check("fault", 32'(hall_fault), 32'(m_fault));
        check("step", 32'(step_count), 32'(m_step));
        check("shoot_through", 32'(shoot), 32'd0);
    endtask

    task automatic hold(input logic [2:0] code, input int n);
        hall_values = code;
        for (int i = 0; i < n; i++) begin
            if (jitter && $urandom_range(0, 39) == 0) dir_cmd = ~dir_cmd;
            cycle();
        end
    endtask

    // Reset is asserted between clock edges and checked before any edge can occur.
    task automatic do_reset();
        #2 preset_n = 1'b0;
        #1;
        check("rst_phase", 32'(phase_enable), 32'd0);
        check("rst_dir", 32'(detected_dir), 32'd0);
        check("rst_fault", 32'(hall_fault), 32'd0);
        check("rst_step", 32'(step_count), 32'd0);
        model_reset();
        @(negedge pclk);
        preset_n = 1'b1;
    endtask

    initial begin
        int r, s;
        enable = 1'b0; dir_cmd = 1'b0; brake = 1'b0; dead_time = 8'd3; hall_values = 3'b000;
        model_reset();
        do_reset();

        // Hold 001 with enable: acceptance at edge 6, gap on 7..9, drive at 10.
        enable = 1'b1;
        hall_values = 3'b001;
        repeat (9) cycle();
        check("s1_gap", 32'(phase_enable), 32'd0);
        cycle();
        check("s1_drive", 32'(phase_enable), 32'b001001);

        for (int i = 1; i <= 6; i++) hold(CODES[i % 6], 12);
        check("fwd_step", 32'(step_count), 32'd6);
        check("fwd_dir", 32'(detected_dir), 32'd1);

        dead_time = 8'd0;
        brake = 1'b1;
        cycle();
        check("brake_now", 32'(phase_enable), 32'b101010);
        dead_time = 8'd4;
        brake = 1'b0;
        cycle();
        cycle();
        dir_cmd = 1'b1;
        cycle();
        repeat (3) cycle();
        check("gap_restart", 32'(phase_enable), 32'd0);
        cycle();
        check("rev_pattern", 32'(phase_enable), 32'b000110);

        dir_cmd = 1'b0;
        dead_time = 8'd3;
        hold(3'b111, 10);
        check("fault_set", 32'(hall_fault), 32'd1);
        check("fault_off", 32'(phase_enable), 32'd0);
        hold(3'b001, 10);
        check("fault_sticky", 32'(hall_fault), 32'd1);
        enable = 1'b0;
        cycle();
        check("fault_clear", 32'(hall_fault), 32'd0);
        enable = 1'b1;
        hold(3'b001, 10);

        do_reset();
        hold(3'b001, 10);
        for (int i = 5; i >= 0; i--) hold(CODES[i], 12);
        check("rev_step", 32'(step_count), 32'h0000FFFA);
        check("rev_dir", 32'(detected_dir), 32'd2);
        hold(3'b011, 1);
        hold(3'b001, 10);
        check("glitch_step", 32'(step_count), 32'h0000FFFA);
        check("glitch_dir", 32'(detected_dir), 32'd2);

        do_reset();
        hold(3'b001, 10);
        hold(3'b011, 10);
        dead_time = 8'd8;
        dir_cmd = 1'b1;
        cycle();
        cycle();
        do_reset();
        dir_cmd = 1'b0;
        dead_time = 8'd2;
        hold(3'b011, 10);
        check("post_rst_step", 32'(step_count), 32'd0);
        hold(3'b010, 10);

        jitter = 1'b1;
        s = 2;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            enable = 1'b1;
            if ($urandom_range(0, 9) == 0) dir_cmd = ~dir_cmd;
            if ($urandom_range(0, 11) == 0) brake = ~brake;
            if ($urandom_range(0, 7) == 0) dead_time = 8'($urandom_range(0, 5));
            if (r < 45) s = (s + 1) % 6;
            else if (r < 75) s = (s + 5) % 6;
            else if (r < 83) s = (s + $urandom_range(2, 4)) % 6;
            else if (r < 90) hold(CODES[(s + $urandom_range(1, 5)) % 6], $urandom_range(1, 3));
            else if (r < 94) hold(($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000,
                                  $urandom_range(2, 10));
            else begin
                enable = 1'b0;
                hold(CODES[s], $urandom_range(1, 3));
                enable = 1'b1;
            end
            hold(CODES[s], $urandom_range(1, 14));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
